// File: rtl/booth_radix4.sv
// booth_radix4: sequential signed radix-4 Booth multiplier, operands strobed serially on one bus.
// Optional BOOTH_GET_SYNC_EN inserts a 2-flop synchronizer on get ahead of the edge detector.
module booth_radix4 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in,
    input  logic               start,
    input  logic               get,
    output logic               ready,
    output logic [2*WIDTH-1:0] out
);
    localparam int CW = $clog2(WIDTH/2+1);
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, CALC, DONE} state_t;
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d, q_q, q_d;
    logic [WIDTH+1:0]   acc_q, acc_d;
    logic               qm1_q, qm1_d, get_q, ready_q, ready_d, get_s, cap;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] out_q, out_d;
    logic [WIDTH+1:0]   m_ext, addend, sum;
    logic [2:0]         sel;
    logic signed [2*WIDTH+2:0] sh;
`ifdef BOOTH_GET_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst)
        if (!rst) sync_q <= '0;
        else      sync_q <= {sync_q[0], get};
    assign get_s = sync_q[1];
`else
    assign get_s = get;
`endif
    assign cap    = get_s & ~get_q;
    assign sel    = {q_q[1:0], qm1_q};
    assign m_ext  = {{2{m_q[WIDTH-1]}}, m_q};
    assign addend = (sel == 3'b001 || sel == 3'b010) ? m_ext :
                    (sel == 3'b011)                  ? m_ext << 1 :
                    (sel == 3'b100)                  ? -(m_ext << 1) :
                    (sel == 3'b101 || sel == 3'b110) ? -m_ext : '0;
    assign sum    = acc_q + addend;
    // {acc,Q,q_m1} shifted as one signed word; acc's two guard bits keep -2^(W-1)^2 exact
    assign sh     = $signed({sum, q_q, qm1_q}) >>> 2;
    assign ready  = ready_q;
    assign out    = out_q;
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        q_d     = q_q;
        acc_d   = acc_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        out_d   = out_q;
        if (start && state_q != IDLE) begin
            state_d = LOAD_A;
            ready_d = 1'b0;
        end else begin
            case (state_q)
                IDLE:   if (start) state_d = LOAD_A;
                LOAD_A: if (cap) begin
                    m_d     = in;
                    state_d = LOAD_B;
                end
                LOAD_B: if (cap) begin
                    q_d     = in;
                    acc_d   = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
                CALC: begin
                    acc_d = sh[2*WIDTH+2:WIDTH+1];
                    q_d   = sh[WIDTH:1];
                    qm1_d = sh[0];
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH/2-1)) begin
                        out_d   = sh[2*WIDTH:1];
                        state_d = DONE;
                    end
                end
                DONE: begin
                    ready_d = ~cap;
                    if (cap) begin
                        m_d     = in;
                        state_d = LOAD_B;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            get_q   <= 1'b0;
            ready_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            get_q   <= get_s;
            ready_q <= ready_d;
            out_q   <= out_d;
        end
    end
endmodule

// File: tb/tb_booth_radix4.sv
// tb_booth_radix4: randomized and directed checks of booth_radix4 against a signed-multiply model.
module tb_booth_radix4;
    localparam int W = 8;
`ifdef BOOTH_GET_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, get = 1'b0;
    logic [W-1:0]   in_v = '0;
    logic           ready;
    logic [2*W-1:0] out_v;
    logic [2*W-1:0] last_p = '0;
    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    booth_radix4 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in(in_v), .start(start), .get(get), .ready(ready), .out(out_v)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[2*W-1:0];
    endfunction

    task automatic pulse_get(input logic [W-1:0] v);
        @(negedge clk); in_v = v; get = 1'b1;
        @(negedge clk); get = 1'b0;
        repeat (SL) @(negedge clk);
    endtask

    task automatic start_pulse();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // multiplier strobe, then exact latency: ready low W/2 cycles, high on the next
    task automatic finish_pair(input logic [W-1:0] b, input logic [2*W-1:0] exp, input bit inj);
        pulse_get(b);
        for (int i = 1; i <= W/2; i++) begin
            @(negedge clk);
            if (inj && i == 1) begin in_v = ~b; get = 1'b1; end
            if (inj && i == 2) get = 1'b0;
            check("calc_rdy", 32'(ready), 32'd0);
        end
        @(negedge clk);
        check("done_rdy", 32'(ready), 32'd1);
        check("product", 32'(out_v), 32'(exp));
        last_p = exp;
    endtask

    task automatic run_pair(input logic [W-1:0] a, input logic [W-1:0] b, input bit inj);
        pulse_get(a);
        check("mcap_rdy", 32'(ready), 32'd0);
        finish_pair(b, model(a, b), inj);
    endtask

    initial begin
        logic [W-1:0] a, b;
        #1;
        check("rst_rdy", 32'(ready), 32'd0);
        check("rst_out", 32'(out_v), 32'd0);
        #20; @(negedge clk); rst = 1'b1;
        pulse_get(8'h55);
        pulse_get(8'h33);
        check("idle_rdy", 32'(ready), 32'd0);
        check("idle_out", 32'(out_v), 32'd0);
        start_pulse();
        run_pair(8'hF9, 8'hFF, 1'b0);
        check("f9ff", 32'(out_v), 32'h0007);
        run_pair(8'hF8, 8'hFF, 1'b0);
        check("f8ff", 32'(out_v), 32'h0008);
        run_pair(8'h80, 8'h80, 1'b0);
        check("8080", 32'(out_v), 32'h4000);
        run_pair(8'h7F, 8'h80, 1'b0);
        check("7f80", 32'(out_v), 32'hC080);
        run_pair(8'h08, 8'h00, 1'b0);
        check("0800", 32'(out_v), 32'h0000);
        // get held high: only the first rising edge may capture
        @(negedge clk); in_v = 8'h13; get = 1'b1;
        repeat (SL + 1) @(negedge clk);
        in_v = 8'hA5;
        repeat (9 - SL) @(negedge clk);
        get = 1'b0;
        repeat (SL + 1) @(negedge clk);
        check("held_rdy", 32'(ready), 32'd0);
        finish_pair(8'hFA, model(8'h13, 8'hFA), 1'b0);
        // strobe during CALC must be ignored
        run_pair(8'hC3, 8'h5B, 1'b1);
        run_pair(8'h21, 8'hE7, 1'b0);
        // start from DONE: ready drops, out held
        start_pulse();
        check("start_rdy", 32'(ready), 32'd0);
        check("start_out", 32'(out_v), 32'(last_p));
        // start in LOAD_B returns to LOAD_A
        pulse_get(8'h3C);
        start_pulse();
        run_pair(8'h6D, 8'h92, 1'b0);
        // async reset mid-CALC
        pulse_get(8'h77);
        pulse_get(8'h99);
        @(negedge clk); rst = 1'b0;
        #1;
        check("mrst_rdy", 32'(ready), 32'd0);
        check("mrst_out", 32'(out_v), 32'd0);
        @(negedge clk); rst = 1'b1;
        pulse_get(8'h12);
        pulse_get(8'h34);
        repeat (W/2 + 2) @(negedge clk);
        check("post_rdy", 32'(ready), 32'd0);
        check("post_out", 32'(out_v), 32'd0);
        start_pulse();
        for (int k = 0; k < 24; k++) begin
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 3) == 0) start_pulse();
            run_pair(a, b, $urandom_range(0, 4) == 0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
